// File: rtl/tx_fsm_pkg.sv
// Shared definitions for the tx_fsm ARQ transmit block: FSM state encoding,
// error-injection mode codes and TinyTapeout pin bit positions.
package tx_fsm_pkg;

    // State codes are visible on uio_out[5:4], so the encoding is fixed.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StRetx = 2'd2,
        StFail = 2'd3
    } tx_state_e;

    // Injected error modes, sampled from ui_in[1:0] when a word is popped.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DROP    = 2'b01;
    localparam logic [1:0] ERR_RETX    = 2'b10;
    localparam logic [1:0] ERR_PERSIST = 2'b11;

    // ui_in fields
    localparam int unsigned UI_WR_EN    = 7;
    localparam int unsigned UI_RD_EN    = 6;
    localparam int unsigned UI_DATA_LSB = 2;
    localparam int unsigned UI_ERR_LSB  = 0;

    // uo_out fields
    localparam int unsigned UO_DATA_LSB = 0;
    localparam int unsigned UO_ACK      = 4;
    localparam int unsigned UO_NACK     = 5;
    localparam int unsigned UO_FULL     = 6;
    localparam int unsigned UO_EMPTY    = 7;

    // uio_out fields
    localparam int unsigned UIO_CNT_LSB   = 0;
    localparam int unsigned UIO_STATE_LSB = 4;
    localparam int unsigned UIO_FAIL      = 6;
    localparam int unsigned UIO_BUSY      = 7;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with a combinational head output. DEPTH must be a power
// of two in the range 2..8 so the 4-bit count and the pointer wrap are exact.
module tx_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [3:0]       count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;

    // Pointer and occupancy next-state; the caller never pushes into a full
    // FIFO unless it also pops, nor pops an empty one.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == 4'(DEPTH));
    assign empty = (count_q == 4'd0);

endmodule

// File: rtl/tx_fsm.sv
// ARQ transmit block for the TinyTapeout harness: a 4-bit FIFO fed from the
// input pins and an FSM that pops one word per read and answers with
// ack / nack / retransmit according to the latched error mode.
// Build option: TX_FSM_PERSIST_RETRY_EN enables the persistent-error retry
// loop and FAIL state; without it mode 11 behaves as mode 00.
module tx_fsm
    import tx_fsm_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       wr_en, rd_en;
    logic [3:0] data_in;
    logic [1:0] err_mode;

    logic       fifo_push, fifo_pop;
    logic [3:0] fifo_dout, fifo_count;
    logic       fifo_full, fifo_empty;

    tx_state_e  state_q, state_d;
    logic [3:0] tx_data_q, tx_data_d;
    logic [1:0] mode_q, mode_d;
    logic [3:0] data_out_q, data_out_d;
    logic       ack_q, ack_d;
    logic       nack_q, nack_d;
    logic       fail_bit;

`ifdef TX_FSM_PERSIST_RETRY_EN
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_q, retry_d;
    logic          fail_q, fail_d;
`endif

    // ena and uio_in carry no function in this design.
    logic unused_in;
    assign unused_in = ena ^ (^uio_in);

    assign wr_en    = ui_in[UI_WR_EN];
    assign rd_en    = ui_in[UI_RD_EN];
    assign data_in  = ui_in[UI_DATA_LSB +: 4];
    assign err_mode = ui_in[UI_ERR_LSB +: 2];

    // empty is the pre-write value, so a write and read on an empty FIFO
    // only writes.
    assign fifo_pop  = (state_q == StIdle) && rd_en && !fifo_empty;
    assign fifo_push = wr_en && (!fifo_full || fifo_pop);

    tx_fifo #(
        .WIDTH (4),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state and registered-output logic; pulses default low.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        mode_d     = mode_q;
        data_out_d = data_out_q;
        ack_d      = 1'b0;
        nack_d     = 1'b0;
`ifdef TX_FSM_PERSIST_RETRY_EN
        retry_d    = retry_q;
        fail_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (fifo_pop) begin
                    tx_data_d = fifo_dout;
                    mode_d    = err_mode;
                    state_d   = StSend;
                end
            end
            StSend: begin
                data_out_d = tx_data_q;
                unique case (mode_q)
                    ERR_NONE: begin
                        ack_d   = 1'b1;
                        state_d = StIdle;
                    end
                    ERR_DROP: begin
                        nack_d  = 1'b1;
                        state_d = StIdle;
                    end
                    ERR_RETX: begin
                        nack_d  = 1'b1;
                        state_d = StRetx;
                    end
                    ERR_PERSIST: begin
`ifdef TX_FSM_PERSIST_RETRY_EN
                        nack_d  = 1'b1;
                        retry_d = RW'(1);
                        state_d = StRetx;
`else
                        ack_d   = 1'b1;
                        state_d = StIdle;
`endif
                    end
                endcase
            end
            StRetx: begin
                data_out_d = tx_data_q;
`ifdef TX_FSM_PERSIST_RETRY_EN
                if (mode_q == ERR_PERSIST) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        nack_d  = 1'b1;
                        retry_d = retry_q + 1'b1;
                    end else begin
                        // fail is raised on entry so it is high while in FAIL
                        fail_d  = 1'b1;
                        state_d = StFail;
                    end
                end else begin
                    ack_d   = 1'b1;
                    state_d = StIdle;
                end
`else
                ack_d   = 1'b1;
                state_d = StIdle;
`endif
            end
            StFail: begin
`ifdef TX_FSM_PERSIST_RETRY_EN
                retry_d = '0;
`endif
                state_d = StIdle;
            end
        endcase
    end

    // FSM and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tx_data_q  <= '0;
            mode_q     <= ERR_NONE;
            data_out_q <= '0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
`ifdef TX_FSM_PERSIST_RETRY_EN
            retry_q    <= '0;
            fail_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            mode_q     <= mode_d;
            data_out_q <= data_out_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
`ifdef TX_FSM_PERSIST_RETRY_EN
            retry_q    <= retry_d;
            fail_q     <= fail_d;
`endif
        end
    end

`ifdef TX_FSM_PERSIST_RETRY_EN
    assign fail_bit = fail_q;
`else
    assign fail_bit = 1'b0;
`endif

    // Pin mapping.
    always_comb begin
        uo_out                        = '0;
        uo_out[UO_DATA_LSB +: 4]      = data_out_q;
        uo_out[UO_ACK]                = ack_q;
        uo_out[UO_NACK]               = nack_q;
        uo_out[UO_FULL]               = fifo_full;
        uo_out[UO_EMPTY]              = fifo_empty;
        uio_out                       = '0;
        uio_out[UIO_CNT_LSB +: 4]     = fifo_count;
        uio_out[UIO_STATE_LSB +: 2]   = state_q;
        uio_out[UIO_FAIL]             = fail_bit;
        uio_out[UIO_BUSY]             = (state_q != StIdle);
    end

    assign uio_oe = 8'hFF;

endmodule

// File: tb/tb_tx_fsm.sv
// Scoreboard bench for tx_fsm: read tasks queue the expected responses and a
// forked monitor pops and compares on every ack/nack/fail pulse.
module tb_tx_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    typedef struct packed {
        logic [3:0] data;
        logic       ack;
        logic       nack;
        logic       fail;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    tx_fsm #(
        .DEPTH     (8),
        .MAX_RETRY (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] d);
        ui_in = {1'b1, 1'b0, d, 2'b00};
        tick();
        ui_in = 8'h00;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (uio_out[7] && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("idle_timeout", {31'd0, uio_out[7]}, 32'd0);
    endtask

    task automatic rd(input logic [1:0] mode);
        ui_in = {1'b0, 1'b1, 4'h0, mode};
        tick();
        ui_in = 8'h00;
        wait_idle();
    endtask

    task automatic expect_resp(input logic [3:0] d, input logic a, input logic n,
                               input logic f);
        resp_t r;
        r.data = d; r.ack = a; r.nack = n; r.fail = f;
        exp_q.push_back(r);
    endtask

    task automatic monitor();
        resp_t act, req;
        forever begin
            @(negedge clk);
            if (!rst && (uo_out[4] || uo_out[5] || uio_out[6])) begin
                act = {uo_out[3:0], uo_out[4], uo_out[5], uio_out[6]};
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", {25'd0, act}, 32'd0);
                end else begin
                    req = exp_q.pop_front();
                    chk("resp", {25'd0, act}, {25'd0, req});
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            monitor();
        join_none

        // Reset and idle state
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_uo_out", {24'd0, uo_out}, 32'h80);
        chk("reset_uio_out", {24'd0, uio_out}, 32'h00);
        chk("uio_oe", {24'd0, uio_oe}, 32'hFF);

        // Fill with 0, A, 3, 2
        wr(4'h0); wr(4'hA); wr(4'h3); wr(4'h2);
        chk("count_after_4", {28'd0, uio_out[3:0]}, 32'd4);
        chk("empty_after_4", {31'd0, uo_out[7]}, 32'd0);

        // Mode 00: ack with data 0; count drops on the pop edge
        expect_resp(4'h0, 1'b1, 1'b0, 1'b0);
        ui_in = 8'b0100_0000;
        tick();
        ui_in = 8'h00;
        chk("count_after_pop", {28'd0, uio_out[3:0]}, 32'd3);
        chk("state_send", {30'd0, uio_out[5:4]}, 32'd1);
        wait_idle();

        // Mode 01: nack, word A dropped
        expect_resp(4'hA, 1'b0, 1'b1, 1'b0);
        rd(2'b01);

        // Mode 10: nack then ack for word 3
        expect_resp(4'h3, 1'b0, 1'b1, 1'b0);
        expect_resp(4'h3, 1'b1, 1'b0, 1'b0);
        rd(2'b10);

        // Mode 00: word 2, FIFO empties
        expect_resp(4'h2, 1'b1, 1'b0, 1'b0);
        rd(2'b00);
        chk("empty_after_drain", {31'd0, uo_out[7]}, 32'd1);
        chk("data_out_hold", {28'd0, uo_out[3:0]}, 32'h2);

        // Read on empty FIFO: nothing happens
        ui_in = 8'b0100_0010;
        tick();
        ui_in = 8'h00;
        chk("empty_rd_state", {30'd0, uio_out[5:4]}, 32'd0);
        tick();
        chk("empty_rd_busy", {31'd0, uio_out[7]}, 32'd0);

        // Simultaneous write and read on empty: write only
        ui_in = {1'b1, 1'b1, 4'h9, 2'b00};
        tick();
        ui_in = 8'h00;
        chk("wr_rd_empty_count", {28'd0, uio_out[3:0]}, 32'd1);
        chk("wr_rd_empty_state", {30'd0, uio_out[5:4]}, 32'd0);

        // Eight more writes of 9: seven fill, the last is dropped
        for (int i = 0; i < 7; i++) wr(4'h9);
        chk("full_flag", {31'd0, uo_out[6]}, 32'd1);
        chk("full_count", {28'd0, uio_out[3:0]}, 32'd8);
        wr(4'h9);
        chk("dropped_write_count", {28'd0, uio_out[3:0]}, 32'd8);

        // Drain exactly eight words
        for (int i = 0; i < 8; i++) begin
            expect_resp(4'h9, 1'b1, 1'b0, 1'b0);
            rd(2'b00);
        end
        chk("empty_after_full_drain", {31'd0, uo_out[7]}, 32'd1);
        chk("full_cleared", {31'd0, uo_out[6]}, 32'd0);

        // Reset in the middle of a transfer aborts it and empties the FIFO
        wr(4'h7); wr(4'h7);
        ui_in = 8'b0100_0010;
        tick();
        ui_in = 8'h00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_uo_out", {24'd0, uo_out}, 32'h80);
        chk("midrst_uio_out", {24'd0, uio_out}, 32'h00);

        // Mode 11
        wr(4'h5);
`ifdef TX_FSM_PERSIST_RETRY_EN
        for (int i = 0; i < 3; i++) expect_resp(4'h5, 1'b0, 1'b1, 1'b0);
        expect_resp(4'h5, 1'b0, 1'b0, 1'b1);
`else
        expect_resp(4'h5, 1'b1, 1'b0, 1'b0);
`endif
        rd(2'b11);
        chk("empty_after_persist", {31'd0, uo_out[7]}, 32'd1);

        tick();
        tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
